// File: rtl/sobel_pkg.sv
// Shared types for the sobel window path.
//   PIX_W_DEF : default pixel width
//   pixel_t   : one pixel at the default width
//   window_t  : 3x3 neighbourhood, [row][col] with [0][0] = top-left
package sobel_pkg;
  localparam int PIX_W_DEF = 8;

  typedef logic [PIX_W_DEF-1:0] pixel_t;
  typedef pixel_t [2:0][2:0]    window_t;
endpackage

// File: rtl/sobel_line_buffer.sv
// One-line delay: dout is the sample written DEPTH enabled cycles ago.
// The memory is a circular RAM addressed by a single pointer. Each enabled
// cycle reads the oldest entry and overwrites it with din.
//   clk, reset : clock, async active-high reset (pointer only)
//   en         : advance the line by one sample
//   din        : sample written at the pointer
//   dout       : sample leaving the line (combinational read at the pointer)
module sobel_line_buffer #(
  parameter int DEPTH = 352,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  assign dout = mem[ptr];

  // Contents are not reset. Nothing read here reaches a valid window
  // until it has been rewritten.
  always_ff @(posedge clk)
    if (en) mem[ptr] <= din;

  always_ff @(posedge clk or posedge reset)
    if (reset)   ptr <= '0;
    else if (en) ptr <= (ptr == AW'(DEPTH-1)) ? '0 : ptr + AW'(1);
endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 window generator feeding the sobel stage.
// It takes a raster pixel stream and emits every interior 3x3 neighbourhood
// one clock after the accept that completes it.
//   clk, reset      : clock, async active-high reset
//   pix_in          : pixel, raster order
//   pix_valid       : pix_in is consumed this cycle
//   sof             : with pix_valid, pix_in is pixel (0,0)
//   s11..s33        : window, sRC with row 1 at the top and column 1 at the left
//   win_valid       : s11..s33 hold an interior window
//   win_row/win_col : coordinates of the centre pixel s22
//   frame_done      : pulses with the window centred at (H-2, W-2)
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 352,
  parameter int IMG_HEIGHT = 288,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIX_W-1:0]              pix_in,
  input  logic                          pix_valid,
  input  logic                          sof,
  output logic [PIX_W-1:0]              s11, s12, s13,
  output logic [PIX_W-1:0]              s21, s22, s23,
  output logic [PIX_W-1:0]              s31, s32, s33,
  output logic                          win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          frame_done
);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  // Line buffer chain: lb_out[0] is the previous row, lb_out[1] is the row before it.
  logic [1:0][PIX_W-1:0] lb_in, lb_out;

  assign lb_in[0] = pix_in;
  assign lb_in[1] = lb_out[0];

  for (genvar g = 0; g < 2; g++) begin : g_lb
    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb (
      .clk   (clk),
      .reset (reset),
      .en    (pix_valid),
      .din   (lb_in[g]),
      .dout  (lb_out[g])
    );
  end

  logic [RW-1:0] row, cur_row, nxt_row;
  logic [CW-1:0] col, cur_col, nxt_col;
  logic          emit, last;

  // A sof pixel is (0,0) whatever the counters say. Its successors count on from it.
  always_comb begin
    cur_row = sof ? '0 : row;
    cur_col = sof ? '0 : col;
    nxt_row = cur_row;
    nxt_col = cur_col + CW'(1);
    if (cur_col == CW'(IMG_WIDTH-1)) begin
      nxt_col = '0;
      nxt_row = (cur_row == RW'(IMG_HEIGHT-1)) ? '0 : cur_row + RW'(1);
    end
    // Columns 0..1 of a row would mix data from two rows. The col test drops them.
    emit = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    last = (cur_row == RW'(IMG_HEIGHT-1)) && (cur_col == CW'(IMG_WIDTH-1));
  end

  // win[r][c]: r=0 is the top row, c=2 is the newest column.
  logic [2:0][2:0][PIX_W-1:0] win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row        <= '0;
      col        <= '0;
      win        <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        row <= nxt_row;
        col <= nxt_col;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2]  <= lb_out[1];
        win[1][2]  <= lb_out[0];
        win[2][2]  <= pix_in;
        win_valid  <= emit;
        frame_done <= emit && last;
        if (emit) begin
          win_row <= cur_row - RW'(1);
          win_col <= cur_col - CW'(1);
        end
      end
    end
  end

  assign s11 = win[0][0];
  assign s12 = win[0][1];
  assign s13 = win[0][2];
  assign s21 = win[1][0];
  assign s22 = win[1][1];
  assign s23 = win[1][2];
  assign s31 = win[2][0];
  assign s32 = win[2][1];
  assign s33 = win[2][2];
endmodule
